// File: rtl/uart_send_injector.sv
// ---------------------------------------------------------------------------
// uart_send_injector
//
// Sits in series on a UART line between a far endpoint (real_rx) and a victim
// endpoint (bus_tx). In passthrough mode the real line is forwarded with one
// register stage of delay. In inject mode the real line is blocked and locally
// supplied bytes are sent as 8N1-style frames (start bit, NUM_DATA_BITS data
// bits LSB first, one stop bit). The mode only changes while the line is idle
// and nothing is queued, so no real frame or injected frame is ever cut short.
//
// Parameters
//   NUM_DATA_BITS : data bits per frame
//   CLKS_PER_BIT  : sys_clk cycles per bit time (>= 2)
//
// Ports
//   sys_clk     in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   send_select in   requested source: 0 = passthrough, 1 = injected frames
//   send_start  in   one-cycle request to queue send_data
//   send_data   in   byte to inject, captured on the accepting edge
//   send_ready  out  a send_start on this cycle would be accepted
//   real_rx     in   synchronised line from the far endpoint (idle high)
//   bus_tx      out  registered line toward the victim endpoint (idle high)
// ---------------------------------------------------------------------------
module uart_send_injector #(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 104
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     send_select,
    input  logic                     send_start,
    input  logic [NUM_DATA_BITS-1:0] send_data,
    output logic                     send_ready,
    input  logic                     real_rx,
    output logic                     bus_tx
);

    localparam int BIT_W  = $clog2(NUM_DATA_BITS + 1);
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_DATA_BITS - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                   state;
    logic                     eff_sel;
    logic                     hold_full;
    logic [NUM_DATA_BITS-1:0] hold_data;
    logic [NUM_DATA_BITS-1:0] shift_data;
    logic [BIT_W-1:0]         bit_cnt;
    logic [BAUD_W-1:0]        baud_cnt;

    logic baud_last;
    logic accept;
    logic load;
    logic sel_update;
    logic eff_sel_next;
    logic hold_full_next;

    // Next-state terms shared by the holding register and the FSM.
    always_comb begin
        baud_last  = (baud_cnt == BAUD_LAST);
        accept     = send_start & send_ready;
        // The queued byte enters the shifter either from IDLE or straight
        // out of the final stop-bit cycle, giving gapless back-to-back frames.
        load       = hold_full & eff_sel &
                     ((state == IDLE) | ((state == STOP) & baud_last));
        // Source may only switch when nothing is in flight, nothing is
        // queued, and the real line is idle (not mid real frame).
        sel_update = (state == IDLE) & ~hold_full & real_rx;
        eff_sel_next   = sel_update ? send_select : eff_sel;
        hold_full_next = accept | (hold_full & ~load);
    end

    // Effective select, one-entry holding register and the ready flag.
    // send_ready is built from the next-cycle values so it always agrees with
    // the registers it describes.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            eff_sel    <= 1'b0;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            send_ready <= 1'b0;
        end else begin
            eff_sel    <= eff_sel_next;
            hold_full  <= hold_full_next;
            if (accept) begin
                hold_data <= send_data;
            end
            send_ready <= eff_sel_next & ~hold_full_next;
        end
    end

    // Frame FSM with registered line output. bus_tx is produced from the
    // state held before each edge, so the line trails the state by one cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_data <= '0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            bus_tx     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    // Injecting: hold the line idle and drop the real line.
                    bus_tx   <= eff_sel ? 1'b1 : real_rx;
                    if (load) begin
                        shift_data <= hold_data;
                        state      <= START;
                    end
                end

                START: begin
                    bus_tx <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    bus_tx <= shift_data[0];
                    if (baud_last) begin
                        baud_cnt   <= '0;
                        shift_data <= shift_data >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    bus_tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (load) begin
                            shift_data <= hold_data;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    bus_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_send_injector.sv
// ---------------------------------------------------------------------------
// tb_uart_send_injector
//
// Directed bench for uart_send_injector with CLKS_PER_BIT = 4 and
// NUM_DATA_BITS = 8. A per-cycle vector table covers passthrough and source
// switching; hand-written sequences cover whole injected frames, back-to-back
// frames, select change mid-frame and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_send_injector;

    localparam int CPB       = 4;
    localparam int NB        = 8;
    localparam int FRAME_CYC = (NB + 2) * CPB;

    logic          sys_clk;
    logic          rst;
    logic          send_select;
    logic          send_start;
    logic [NB-1:0] send_data;
    logic          send_ready;
    logic          real_rx;
    logic          bus_tx;

    int checks;
    int failures;

    uart_send_injector #(
        .NUM_DATA_BITS(NB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .send_select(send_select),
        .send_start (send_start),
        .send_data  (send_data),
        .send_ready (send_ready),
        .real_rx    (real_rx),
        .bus_tx     (bus_tx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic          rx;
        logic          sel;
        logic          start;
        logic [NB-1:0] data;
        logic          exp_tx;
        logic          exp_rdy;
    } vec_t;

    vec_t vecs[12];

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", nm, got, exp);
        end
    endtask

    // Expected line level for bit slot j of a frame carrying b.
    function automatic logic exp_bit(input logic [NB-1:0] b, input int j);
        if (j == 0)       return 1'b0;
        else if (j <= NB) return b[j-1];
        else              return 1'b1;
    endfunction

    // Called 1 unit after the edge that shows the first start-bit sample.
    // Optionally fires a send_start at sample poke_idx, expecting it to be
    // refused (send_ready low).
    task automatic expect_frame(input logic [NB-1:0] b, input string nm,
                                input int poke_idx, input logic [NB-1:0] poke_d);
        for (int i = 0; i < FRAME_CYC; i++) begin
            chk($sformatf("%s_s%0d", nm, i), bus_tx, exp_bit(b, i / CPB));
            if (i == poke_idx) begin
                chk($sformatf("%s_poke_ready", nm), send_ready, 1'b0);
                send_start = 1'b1;
                send_data  = poke_d;
            end
            tick();
            send_start = 1'b0;
        end
    endtask

    // Queue a byte while send_ready is high; returns 1 unit after the
    // accepting edge.
    task automatic send_byte(input logic [NB-1:0] d);
        send_start = 1'b1;
        send_data  = d;
        tick();
        send_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        send_select = 1'b0;
        send_start  = 1'b0;
        send_data   = '0;
        real_rx     = 1'b1;

        //            rx    sel   start data   tx    rdy
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("reset_bus_tx", bus_tx, 1'b1);
        chk("reset_ready", send_ready, 1'b0);
        rst = 1'b0;

        // Passthrough, blocked switching, ignored starts
        for (int k = 0; k < 12; k++) begin
            real_rx     = vecs[k].rx;
            send_select = vecs[k].sel;
            send_start  = vecs[k].start;
            send_data   = vecs[k].data;
            tick();
            send_start = 1'b0;
            chk($sformatf("vec%0d_tx", k), bus_tx, vecs[k].exp_tx);
            chk($sformatf("vec%0d_rdy", k), send_ready, vecs[k].exp_rdy);
        end

        // Ignored starts must not have queued anything
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("noframe_%0d", k), bus_tx, 1'b1);
        end

        // Single frame 0x24
        send_byte(8'h24);
        chk("f24_ready_after_accept", send_ready, 1'b0);
        chk("f24_tx_e0", bus_tx, 1'b1);
        tick();
        chk("f24_ready_in_start", send_ready, 1'b1);
        chk("f24_tx_e1", bus_tx, 1'b1);
        tick();
        expect_frame(8'h24, "f24", -1, 8'h00);
        chk("f24_idle_after", bus_tx, 1'b1);

        // Back-to-back 0x41 then 0x5A; a third start in DATA is refused
        send_byte(8'h41);
        tick();
        send_byte(8'h5A);
        chk("b2b_ready_full", send_ready, 1'b0);
        expect_frame(8'h41, "f41", 10, 8'h33);
        expect_frame(8'h5A, "f5a", -1, 8'h00);
        for (int k = 0; k < 50; k++) begin
            chk($sformatf("b2b_idle_%0d", k), bus_tx, 1'b1);
            tick();
        end

        // Select drops mid-frame while the real line is busy
        send_byte(8'h3C);
        tick();
        send_select = 1'b0;
        real_rx     = 1'b0;
        tick();
        expect_frame(8'h3C, "f3c", -1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sel_blocked_tx_%0d", k), bus_tx, 1'b1);
            chk($sformatf("sel_blocked_rdy_%0d", k), send_ready, 1'b1);
            tick();
        end
        real_rx = 1'b1;
        tick();
        chk("sel_switch_rdy", send_ready, 1'b0);
        chk("sel_switch_tx", bus_tx, 1'b1);
        real_rx = 1'b0;
        tick();
        chk("pass_resumed_0", bus_tx, 1'b0);
        real_rx = 1'b1;
        tick();
        chk("pass_resumed_1", bus_tx, 1'b1);

        // Reset during DATA with a byte queued
        send_select = 1'b1;
        tick();
        chk("rst_pre_ready", send_ready, 1'b1);
        send_byte(8'h55);
        tick();
        send_byte(8'h66);
        chk("rst_queued_ready", send_ready, 1'b0);
        repeat (8) tick();
        chk("rst_in_data_tx", bus_tx, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_tx", bus_tx, 1'b1);
        chk("rst_mid_ready", send_ready, 1'b0);
        for (int k = 0; k < 60; k++) begin
            tick();
            chk($sformatf("rst_quiet_%0d", k), bus_tx, 1'b1);
        end
        chk("rst_rearm_ready", send_ready, 1'b1);
        send_byte(8'hC3);
        tick();
        tick();
        expect_frame(8'hC3, "fc3", -1, 8'h00);
        chk("fc3_idle_after", bus_tx, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_send_injector.md
UART_SEND_INJECTOR -- requirements
Module: uart_send_injector

Interface
REQ-001 Parameter NUM_DATA_BITS, default 8, SHALL set the data bits per UART frame.
REQ-002 Parameter CLKS_PER_BIT, default 104, SHALL set the sys_clk cycles per bit (minimum 2).
REQ-003 sys_clk  input  1  SHALL be the system clock; all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 send_select  input  1  SHALL be the request for the source of bus_tx (0 = real passthrough, 1 = injected frames).
REQ-006 send_start  input  1  SHALL be a single-cycle request to transmit send_data.
REQ-007 send_data  input  NUM_DATA_BITS  SHALL be the byte to inject, sampled on the accepting edge.
REQ-008 send_ready  output  1  SHALL be high when a send_start would be accepted.
REQ-009 real_rx  input  1  SHALL be the genuine line from the far endpoint; it is already synchronised, and idle is high.
REQ-010 bus_tx  output  1  SHALL be the line driven toward the victim endpoint; it is registered, and idle is high.

Function
REQ-011 The block SHALL hold an effective-select register (eff_sel) that is updated from send_select only when all of the following hold in the same cycle:
- the FSM is in IDLE;
- the holding register is empty;
- real_rx = 1.
REQ-012 While eff_sel = 0, bus_tx SHALL equal real_rx delayed by exactly one cycle, and the FSM SHALL remain in IDLE.
REQ-013 send_ready SHALL be registered, and SHALL equal (eff_sel = 1) AND (holding register empty).
REQ-014 A start SHALL be accepted iff send_start = 1 and send_ready = 1 at the same edge.
- On acceptance, send_data is copied into a one-entry holding register.
- send_ready deasserts in the next cycle.
REQ-015 A send_start with send_ready = 0 SHALL be ignored, with no side effects.
REQ-016 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-017 IDLE -> START SHALL occur on the first edge at which the holding register is full and eff_sel = 1.
- On that edge, the holding register moves into the shift register and the holding register becomes empty.
REQ-018 START SHALL drive bus_tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA SHALL drive NUM_DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-020 STOP SHALL drive bus_tx = 1 for CLKS_PER_BIT cycles.
- If the holding register is full, the FSM goes directly to START (back-to-back frames with no idle gap).
- Otherwise the FSM goes to IDLE.
REQ-021 The first bus_tx = 0 of a frame SHALL appear 2 cycles after the accepting edge when the FSM was IDLE.
- A full frame SHALL last (NUM_DATA_BITS + 2) * CLKS_PER_BIT cycles.
REQ-022 Because the holding register empties at frame start, send_ready SHALL reassert during START. This allows exactly one queued byte per frame in flight.
REQ-023 A change of send_select during a frame, or while the holding register is full, SHALL have no effect until the condition in REQ-011 holds.
REQ-024 The bit counter SHALL be sized ceil(log2(NUM_DATA_BITS + 1)), and the baud counter SHALL be sized ceil(log2(CLKS_PER_BIT)). Neither counter SHALL wrap within a state.
REQ-025 In IDLE with eff_sel = 1, bus_tx SHALL be 1. real_rx is discarded (blocked).

Reset
REQ-026 rst SHALL be synchronous and active-high, and SHALL take precedence over all other logic.
REQ-027 Under reset the block SHALL set:
- bus_tx = 1, send_ready = 0, eff_sel = 0;
- FSM = IDLE;
- holding register and shift register empty, with value 0;
- all counters = 0.
REQ-028 An rst asserted mid-frame SHALL abort the frame. bus_tx SHALL be 1 in the cycle after the rst edge, and the queued byte SHALL be discarded.

Verification (CLKS_PER_BIT = 4, NUM_DATA_BITS = 8)
REQ-029 Stimulus: send_select = 0, real_rx toggles 1,0,0,1. Required: bus_tx shows 1,0,0,1 one cycle later, and send_ready stays 0.
REQ-030 Stimulus: send_select = 1 with line idle, then one-cycle send_start with 0x24. Required:
- bus_tx = 0 for cycles 2-5 after the accepting edge;
- then the bits 0,0,1,0,0,1,0,0, 4 cycles each;
- then the stop bit, 1 for 4 cycles;
- total 40 cycles.
REQ-031 Stimulus: 0x41 accepted, then 0x5A accepted during START of the 0x41 frame. Required:
- the 0x5A start bit follows the 0x41 stop bit with zero gap;
- a third send_start issued during the 0x41 DATA state is ignored.
REQ-032 Stimulus: send_select goes 1 -> 0 mid-frame. Required: the frame completes unchanged, and bus_tx returns to passthrough only after IDLE and real_rx = 1.
REQ-033 Stimulus: rst pulsed during DATA with a byte queued. Required:
- the next cycle shows bus_tx = 1 and send_ready = 0;
- no further frame is sent until send_select and send_start are reapplied.
REQ-034 Stimulus: send_select = 1 while real_rx = 0 (a real frame in progress). Required: eff_sel stays 0 until real_rx = 1, so the real start bit is passed through intact.
